// File: rtl/rv32i_defines.sv
// Shared definitions for the RV32I multi-cycle core.
// Holds the fetch-stage state encoding and the default reset PC.
package rv32i_defines;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues one word read per instruction and
// hands the word plus its PC to decode; execute can redirect at any time.
module instruction_fetch
  import rv32i_defines::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fault
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         squash, squash_next;
  logic         capture;
  logic         redirect_live;
  logic         redirect_ok;
  logic         redirect_bad;

  function automatic logic [31:0] pc_plus_4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign redirect_live = redirect_valid &&
                         ((state == S_REQ) || (state == S_WAIT) || (state == S_HOLD));
  assign redirect_ok   = redirect_live && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad  = redirect_live && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    squash_next = squash;
    capture     = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        // A request accepted alongside a redirect fetches from the wrong path.
        if (mem_req_ready) begin
          state_next  = S_WAIT;
          squash_next = redirect_ok;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (squash || redirect_ok) begin
            state_next  = S_REQ;
            squash_next = 1'b0;
          end else begin
            capture    = 1'b1;
            pc_next    = pc_plus_4(pc);
            state_next = S_HOLD;
          end
        end else if (redirect_ok) begin
          squash_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) state_next = S_REQ;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase

    if (redirect_ok) begin
      pc_next = redirect_pc;
      if (state == S_HOLD) state_next = S_REQ;
    end

    // A misaligned target is fatal; the PC keeps the last good value.
    if (redirect_bad) begin
      state_next  = S_FAULT;
      pc_next     = pc;
      squash_next = squash;
      capture     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      pc              <= RESET_PC;
      squash          <= 1'b0;
      instr           <= '0;
      instr_pc        <= '0;
      instr_pc_plus_4 <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      squash <= squash_next;
      if (capture) begin
        instr           <= mem_resp_data;
        instr_pc        <= pc;
        instr_pc_plus_4 <= pc_plus_4(pc);
      end
    end
  end

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = pc;
  assign instr_valid   = (state == S_HOLD);
  assign fault         = (state == S_FAULT);

  a_legal_state: assert property (@(posedge clk) disable iff (!rst)
    (state == S_IDLE) || (state == S_REQ) || (state == S_WAIT) ||
    (state == S_HOLD) || (state == S_FAULT));

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the multi-cycle RV32I core, directly upstream of the instruction decoder. Holds the program counter, issues one word read per instruction over a valid/ready request and valid response memory interface, and presents the fetched word with its PC to decode under a valid/ready handshake. Branch and jump targets from execute arrive on a redirect port that squashes any in-flight or held instruction.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset. Must be word aligned.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserted when 0.
- `mem_req_valid` out 1: read request valid.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_addr` out 32: read address, always equal to `pc`.
- `mem_resp_valid` in 1: read data valid. Arrives at the earliest one cycle after acceptance.
- `mem_resp_data` in 32: read data.
- `redirect_valid` in 1: load a new PC, discarding the current fetch.
- `redirect_pc` in 32: redirect target.
- `instr` out 32: fetched instruction word. Drives the decoder's `instr`.
- `instr_pc` out 32: address `instr` was fetched from.
- `instr_pc_plus_4` out 32: `instr_pc + 4`.
- `instr_valid` out 1: `instr` and its PCs are valid.
- `instr_ready` in 1: decode consumes the instruction this cycle. This is the decoder's `ena`.
- `fault` out 1: sticky misaligned-redirect fault.

## Operation
- **States:** `S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD`, `S_FAULT`. Internal registers are `pc` and `squash`.
- **Reset:**
  - State is `S_IDLE`, `pc` is `RESET_PC`, `squash` is 0.
  - Outputs: `instr` = 0, `instr_pc` = 0, `instr_pc_plus_4` = 0, `instr_valid` = 0, `fault` = 0, `mem_req_valid` = 0.
- **`S_IDLE`:** go to `S_REQ` unconditionally.
- **`S_REQ`:**
  - `mem_req_valid` = 1.
  - If `mem_req_ready` = 1, go to `S_WAIT`. Otherwise stay.
- **`S_WAIT`:**
  - `mem_req_valid` = 0.
  - On `mem_resp_valid`, if `squash` = 0:
    - capture `instr` = `mem_resp_data`, `instr_pc` = `pc`, `instr_pc_plus_4` = `pc + 4`;
    - set `pc` = `pc + 4` and `instr_valid` = 1;
    - go to `S_HOLD`.
  - On `mem_resp_valid`, if `squash` = 1: discard the data, clear `squash`, go to `S_REQ`.
- **`S_HOLD`:**
  - `instr_valid` = 1. `instr`, `instr_pc` and `instr_pc_plus_4` are held stable.
  - On `instr_ready`: clear `instr_valid` and go to `S_REQ`.
- **`S_FAULT`:**
  - Terminal state until reset.
  - `mem_req_valid` = 0, `instr_valid` = 0, `fault` = 1.
  - `redirect_valid` is ignored.
- **Redirect, aligned target** (`redirect_pc[1:0]` = 0), in any state except `S_IDLE` and `S_FAULT`:
  - Set `pc` = `redirect_pc` and `instr_valid` = 0.
  - Next state by current state:
    - `S_REQ` without handshake: stay in `S_REQ` with the new address.
    - `S_REQ` with `mem_req_ready` = 1 in the same cycle: go to `S_WAIT` with `squash` = 1, because the accepted request is wrong-path.
    - `S_WAIT`: set `squash` = 1 and stay. If `mem_resp_valid` is also high, drop the data, go to `S_REQ` and leave `squash` = 0.
    - `S_HOLD`: go to `S_REQ`. Redirect wins over a simultaneous `instr_ready`.
- **Redirect, misaligned target:** set `fault` = 1, go to `S_FAULT`, leave `pc` unchanged.
- **Ignored inputs:**
  - `mem_resp_valid` outside `S_WAIT`.
  - `instr_ready` while `instr_valid` = 0.
- **Arithmetic:** all PC arithmetic is 32-bit unsigned, wrapping modulo 2^32. `32'hFFFF_FFFC + 4` = 0.
- **Memory address rule:** `mem_req_addr` may change while `mem_req_valid` is high, but only on redirect. Memory samples the address only in the handshake cycle.

## Timing
- `mem_req_valid` first rises in the second cycle after `rst` deasserts (cycle 0 is `S_IDLE`).
- Zero-wait memory (ready = 1, response one cycle after acceptance) and decode ready: `S_REQ`, `S_WAIT`, `S_HOLD`, so 3 cycles per instruction.
- `instr_valid` rises the cycle after `mem_resp_valid`.
- A redirect takes effect on the next edge. The new PC appears on `mem_req_addr` in the following cycle.
- Asserting `rst` mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.
- Any outstanding memory response after reset is ignored, because the block is not in `S_WAIT`.

## Structure
- `fetch_state_t` enum goes in `rv32i_defines.sv`.
- A `PC_RESET_DEFAULT` constant goes in `rv32i_defines.sv`.
- A `PANIC` on illegal state encoding is for simulation only.
- Single module, no sub-module. The PC register and next-PC mux are small enough to inline.

## Test plan
- **Reset and first fetch:** `RESET_PC` = 0x100, ready = 1, response data 0x00500093 one cycle later, `instr_ready` = 1. Expect:
  - `mem_req_addr` = 0x100;
  - `instr` = 0x00500093, `instr_pc` = 0x100, `instr_pc_plus_4` = 0x104;
  - next request to 0x104.
- **Backpressure:**
  - Hold `mem_req_ready` = 0 for 4 cycles: `mem_req_valid` stays high and the address stays at 0x104.
  - Hold `instr_ready` = 0 for 5 cycles: `instr` stays stable and `mem_req_valid` = 0 throughout.
- **Redirect in `S_WAIT`:** redirect_pc = 0x200, response arrives 2 cycles later. Expect the response to be dropped, `instr_valid` to stay 0, and the next request to go to 0x200.
- **Simultaneous events:**
  - Redirect to 0x300 in the same cycle as the `S_REQ` handshake: the response is squashed and the next request goes to 0x300.
  - Redirect in `S_HOLD` together with `instr_ready`: `instr_valid` falls and the next request goes to the redirect target.
- **Fault and wrap:**
  - Redirect to 0x202: `fault` = 1, no further requests, and reset clears it.
  - Fetch at 0xFFFFFFFC: `instr_pc_plus_4` = 0 and the next request goes to 0x0.
